// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its PC register.
package cpu_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_REDIRECT
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR   = 32'h0;
   localparam int unsigned OPCODE_MSB  = 31;
   localparam int unsigned OPCODE_LSB  = 26;
   localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter with async reset, load enable and branch/sequential next-PC mux.
module pc_register
   import cpu_pkg::*;
#(
   parameter int unsigned         ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              sel_branch,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4
);

   logic [ADDR_W-1:0] next_pc;

   // Wraps modulo 2^ADDR_W; no fault on overflow.
   assign pc_plus4 = pc + ADDR_W'(INSTR_BYTES);
   assign next_pc  = sel_branch ? (branch_target & ~ADDR_W'(3)) : pc_plus4;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pc <= RESET_PC;
      else if (load)
         pc <= next_pc;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch FSM and IF/ID pipeline register feeding main_control.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   output logic              ifid_valid,
   output logic [31:0]       ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc_plus4,
   output logic [5:0]        next_opCode
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic              capture;
   logic              pc_load;

   assign capture = (state == S_FETCH) && imem_ready && !flush && !stall;
   assign pc_load = branch_taken || capture;

   pc_register #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk           (clk),
      .reset         (reset),
      .load          (pc_load),
      .sel_branch    (branch_taken),
      .branch_target (branch_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4)
   );

   assign imem_addr   = pc;
   assign next_opCode = ifid_instr[OPCODE_MSB:OPCODE_LSB];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         imem_req      <= 1'b0;
         ifid_valid    <= 1'b0;
         ifid_instr    <= NOP_INSTR;
         ifid_pc_plus4 <= '0;
      end else if (branch_taken) begin
         // Request gap lets memory drop the in-flight access to the old path.
         state      <= S_REDIRECT;
         imem_req   <= 1'b0;
         ifid_valid <= 1'b0;
         ifid_instr <= NOP_INSTR;
      end else begin
         case (state)
            S_IDLE, S_REDIRECT: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
            end
            S_FETCH: imem_req <= 1'b1;
            default: begin
               state    <= S_IDLE;
               imem_req <= 1'b0;
            end
         endcase

         if (flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
         end else if (state == S_FETCH && !stall) begin
            if (imem_ready) begin
               ifid_valid    <= 1'b1;
               ifid_instr    <= imem_rdata;
               ifid_pc_plus4 <= pc_plus4;
            end else begin
               ifid_valid <= 1'b0;
               ifid_instr <= NOP_INSTR;
            end
         end
      end
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of main_control.
- Holds the PC and issues word requests to instruction memory over a ready handshake.
- Captures returned instructions into IF/ID and presents the opcode field as next_opCode to main_control.
- Accepts stall, flush and taken-branch redirects from downstream stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, width of PC and instruction-memory address.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- flush  input  1  kill IF/ID contents (insert bubble).
- branch_taken  input  1  redirect PC this cycle.
- branch_target  input  ADDR_W  redirect address; bits [1:0] ignored, forced to 0.
- imem_req  output  1  fetch request valid.
- imem_addr  output  ADDR_W  fetch address, always equal to the current PC.
- imem_ready  input  1  imem_rdata valid for imem_addr this cycle.
- imem_rdata  input  32  fetched instruction.
- ifid_valid  output  1  IF/ID holds a live instruction.
- ifid_instr  output  32  IF/ID instruction.
- ifid_pc_plus4  output  ADDR_W  address of IF/ID instruction + 4.
- next_opCode  output  6  ifid_instr[31:26], feeds main_control.

Behaviour:
- Reset (async, active-high): pc=RESET_PC, state=S_IDLE, imem_req=0, ifid_valid=0, ifid_instr=32'h0 (NOP), ifid_pc_plus4=0, next_opCode=0.
- FSM states:
  - S_IDLE: imem_req=0; next state S_FETCH. Exactly one cycle after reset release.
  - S_FETCH: imem_req=1, imem_addr=pc.
  - S_REDIRECT: imem_req=0 for one cycle so memory sees a request gap and drops the stale access; next state S_FETCH.
- Event priority, highest first: reset > branch_taken > flush > stall > normal.
- branch_taken, any state:
  - pc<=branch_target&~3.
  - ifid_valid<=0, ifid_instr<=0.
  - A same-cycle imem response is discarded.
  - State<=S_REDIRECT.
- flush, without branch_taken:
  - ifid_valid<=0, ifid_instr<=0.
  - A same-cycle response is discarded and pc does not advance; the same address is re-requested next cycle.
  - State unchanged.
- stall, without branch or flush:
  - pc, ifid_* held.
  - A same-cycle response is discarded; imem_req stays 1 and the fetch is re-issued.
  - Instruction memory reads are side-effect free.
- Normal in S_FETCH:
  - imem_ready=1: ifid_instr<=imem_rdata, ifid_pc_plus4<=pc+4, ifid_valid<=1, pc<=pc+4. Back-to-back fetches give one instruction per cycle.
  - imem_ready=0: ifid_valid<=0, ifid_instr<=0 (bubble); pc held.
- imem_ready is ignored outside S_FETCH.
- Arithmetic: pc+4 is modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0. No exception is raised.
- next_opCode is combinational from ifid_instr. A bubble therefore presents opcode 0 with instr 0; the downstream ifid_valid gate blocks its write-back.
- Latency:
  - Reset release to first imem_req: 1 cycle.
  - ready to IF/ID valid: 1 cycle.
  - branch_taken to first request at target: 2 cycles.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum {S_IDLE, S_FETCH, S_REDIRECT}.
  - NOP_INSTR=32'h0.
  - OPCODE_MSB=31, OPCODE_LSB=26.
  - INSTR_BYTES=4.
- One sub-module, pc_register:
  - Holds PC with async reset to RESET_PC.
  - Load-enable and next-PC mux (branch_target vs pc+4).
  - fetch_stage keeps the FSM and IF/ID register.

Test Plan:
1. Reset held 3 cycles, then released, imem_ready=1 constant, rdata=addr-tagged pattern -> imem_req rises 1 cycle after release; imem_addr 0,4,8 on successive cycles; ifid_pc_plus4 4,8,12; ifid_valid=1 from the second request cycle.
2. Fetch rdata=32'h8C42_0004 (lw) at addr 0 -> next_opCode=6'h23 the following cycle. Then fetch 32'h0043_0820 (add) -> next_opCode=6'h00 with ifid_valid=1.
3. stall high 2 cycles while ready=1 at pc=8 -> imem_addr stays 8; ifid_instr unchanged; after release the instruction at 8 is captured and pc=12.
4. branch_taken=1, branch_target=32'h0000_0043, same cycle as ready=1 -> response discarded; ifid_valid=0; one cycle imem_req=0; then imem_addr=32'h40.
5. flush and stall asserted together with ready=1 -> ifid_valid=0, ifid_instr=0, pc unchanged. Separately, imem_ready=0 for 3 cycles -> 3 bubbles, pc held.
6. RESET_PC=32'hFFFF_FFFC, ready=1 -> second fetch addr=0. Then assert reset mid-stall -> all outputs return to reset values immediately, asynchronously.
